// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
// One operand bit per cycle; results are held in output registers until the next conversion completes.
module binary_to_bcd #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done_tick,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic             overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [BIN_W-1:0] opnd, opnd_next;
    logic [15:0]      work, work_next, work_adj;
    logic             ovf_cap, ovf_cap_next;
    logic             load_out;

    // Digit correction: each nibble is adjusted independently, carries never cross digits.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < 4; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        opnd_next    = opnd;
        work_next    = work;
        ovf_cap_next = ovf_cap;
        load_out     = 1'b0;
        ready        = 1'b0;
        done_tick    = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    opnd_next    = bin;
                    work_next    = 16'd0;
                    cnt_next     = CNT_W'(BIN_W);
                    ovf_cap_next = (32'(bin) > 32'd9999);
                    state_next   = OP;
                end
            end
            OP: begin
                // The ten-thousands bit falls off the top of digit3, leaving bin mod 10000.
                work_next = {work_adj[14:0], opnd[BIN_W-1]};
                opnd_next = {opnd[BIN_W-2:0], 1'b0};
                cnt_next  = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                end
            end
            DONE: begin
                done_tick  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            opnd    <= '0;
            work    <= '0;
            ovf_cap <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            opnd    <= opnd_next;
            work    <= work_next;
            ovf_cap <= ovf_cap_next;
        end
    end

    // Result registers only move when the final shift lands, so they stay stable between conversions.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd3     <= 4'd0;
            bcd2     <= 4'd0;
            bcd1     <= 4'd0;
            bcd0     <= 4'd0;
            overflow <= 1'b0;
        end else if (load_out) begin
            bcd3     <= work_next[15:12];
            bcd2     <= work_next[11:8];
            bcd1     <= work_next[7:4];
            bcd0     <= work_next[3:0];
            overflow <= ovf_cap;
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Testbench for binary_to_bcd: arithmetic reference model checked every cycle, plus literal result checks.
module tb_binary_to_bcd;

    localparam int BIN_W = 14;

    logic             clk;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             ready;
    logic             done_tick;
    logic [3:0]       bcd3, bcd2, bcd1, bcd0;
    logic             overflow;

    int n_vec = 0;
    int n_bad = 0;

    binary_to_bcd #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare1(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a conversion occupies BIN_W+1 non-idle cycles after acceptance; the last is the done cycle.
    int model_busy  = 0;
    int model_pend  = 0;
    int model_val   = 0;
    bit model_ovf   = 1'b0;
    bit model_valid = 1'b0;
    int model_acc   = 0;

    always @(posedge clk) begin
        if (reset) begin
            model_busy  = 0;
            model_val   = 0;
            model_ovf   = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (model_busy == 0) begin
                if (start) begin
                    model_pend = int'(bin);
                    model_busy = BIN_W + 1;
                    model_acc++;
                end
            end else begin
                model_busy--;
                if (model_busy == 1) begin
                    model_val = model_pend % 10000;
                    model_ovf = (model_pend > 9999);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            logic [18:0] act, exp;
            act = {ready, done_tick, overflow, bcd3, bcd2, bcd1, bcd0};
            exp = {(model_busy == 0), (model_busy == 1), model_ovf,
                   4'((model_val / 1000) % 10), 4'((model_val / 100) % 10),
                   4'((model_val / 10) % 10), 4'(model_val % 10)};
            compare1("cycle_model", int'(act), int'(exp));
        end
    end

    task automatic waitDone(output int lat);
        lat = 0;
        while (!done_tick && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done_tick) compare1("done_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int v, output int lat);
        @(negedge clk);
        bin   = BIN_W'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp_bcd, input logic exp_ovf);
        compare1(name, int'({overflow, bcd3, bcd2, bcd1, bcd0}), int'({exp_ovf, exp_bcd}));
    endtask

    task automatic countTicks(input int cycles, output int ticks);
        ticks = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_tick) ticks++;
        end
    endtask

    int lat;
    int ticks;
    int prev_acc;
    int guard;
    int cyc;
    int last_done;

    always @(posedge clk) cyc++;

    initial begin
        cyc   = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_outputs", 16'h0000, 1'b0);
        compare1("reset_ready", int'(ready), 1);

        applyStimulus(0, lat);
        compare1("latency_0", lat, BIN_W);
        checkOutput("bin_0", 16'h0000, 1'b0);

        applyStimulus(1234, lat);
        compare1("latency_1234", lat, BIN_W);
        checkOutput("bin_1234", 16'h1234, 1'b0);
        applyStimulus(9999, lat);
        checkOutput("bin_9999", 16'h9999, 1'b0);
        applyStimulus(10000, lat);
        checkOutput("bin_10000", 16'h0000, 1'b1);
        applyStimulus(16383, lat);
        checkOutput("bin_16383", 16'h6383, 1'b1);
        applyStimulus(7, lat);
        checkOutput("bin_7", 16'h0007, 1'b0);

        // Operand change and start pulse during conversion must be ignored.
        @(negedge clk);
        bin   = BIN_W'(4321);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = BIN_W'(1111);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat);
        checkOutput("bin_4321_ignore", 16'h4321, 1'b0);
        countTicks(20, ticks);
        compare1("single_tick_4321", ticks, 0);

        // Reset sampled at the edge ending the 5th op cycle.
        @(negedge clk);
        bin   = BIN_W'(5678);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_outputs", 16'h0000, 1'b0);
        compare1("abort_ready", int'(ready), 1);
        countTicks(20, ticks);
        compare1("abort_no_tick", ticks, 0);
        applyStimulus(42, lat);
        checkOutput("bin_42", 16'h0042, 1'b0);

        // Sparse sweep across the full operand range; the model checks every cycle.
        for (int v = 0; v < (1 << BIN_W); v += 7) applyStimulus(v, lat);
        applyStimulus(16382, lat);
        checkOutput("bin_16382", 16'h6382, 1'b1);

        // Continuous start: bin advances after each acceptance.
        @(negedge clk);
        bin       = BIN_W'(1);
        start     = 1'b1;
        last_done = 0;
        for (int i = 1; i <= 20; i++) begin
            prev_acc = model_acc;
            guard    = 0;
            while (model_acc == prev_acc && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (model_acc == prev_acc) compare1("accept_timeout", 0, 1);
            bin = BIN_W'(i + 1);
            @(negedge clk);
            waitDone(lat);
            checkOutput("held_start", {8'h00, 4'(i / 10), 4'(i % 10)}, 1'b0);
            if (i > 1) compare1("tick_period", cyc - last_done, BIN_W + 2);
            last_done = cyc;
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 SHALL provide parameter BIN_W, default 14, binary input width; legal range 4..14.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  conversion request, sampled only in idle.
REQ-005 SHALL provide port bin  input  BIN_W  unsigned binary operand, sampled with start.
REQ-006 SHALL provide port ready  output  1  high while idle (combinational from state).
REQ-007 SHALL provide port done_tick  output  1  one-cycle pulse, result valid.
REQ-008 SHALL provide ports bcd3, bcd2, bcd1, bcd0  output  4 each  thousands/hundreds/tens/units digit.
REQ-009 SHALL provide port overflow  output  1  operand exceeded 9999.

Function
REQ-010 SHALL implement a three-state FSM: idle, op, done; unreachable encodings go to idle next cycle.
REQ-011 In idle, ready=1; on start=1 at a rising edge: capture bin into shift register, clear 16-bit BCD work register, load iteration counter with BIN_W, capture overflow_next = (bin > 9999), go to op.
REQ-012 start SHALL be ignored in op and done; bin changes after capture SHALL not affect the result.
REQ-013 Each op cycle SHALL: per work digit, add 3 if digit >= 5 (4-bit, no carry between digits); then shift {work, operand} left one bit, operand MSB entering work digit0 LSB, work digit3 MSB discarded; decrement counter.
REQ-014 After the op cycle in which the counter reaches 0 (exactly BIN_W op cycles), SHALL go to done.
REQ-015 On entry to done, SHALL load bcd3..bcd0 and overflow output registers from the work register and captured flag; outputs SHALL NOT change at any other time except reset.
REQ-016 In done, done_tick=1 for exactly one cycle; next state idle unconditionally.
REQ-017 Latency: start sampled at edge E0 -> done_tick high in cycle after edge E(BIN_W); ready low for BIN_W+1 cycles.
REQ-018 Digits SHALL equal decimal digits of (bin mod 10000); for bin > 9999 (possible only for BIN_W=14) overflow=1, digits = bin-10000.
REQ-019 Every output digit SHALL be in 0..9.
REQ-020 start held high continuously SHALL yield back-to-back conversions separated by exactly one idle cycle; bin re-sampled each time.
REQ-021 done_tick and ready SHALL never be high together.

Reset
REQ-022 reset=1 at a rising edge SHALL force state idle, counter 0, work/operand registers 0, bcd3..bcd0=0, overflow=0, regardless of state.
REQ-023 Reset during op or done SHALL abort the conversion; no done_tick, outputs read 0 the cycle after.
REQ-024 reset has priority over start on the same edge.

Verification
REQ-025 BIN_W=14, bin=0, start 1 cycle -> done_tick 15 cycles after start edge, digits 0,0,0,0, overflow=0.
REQ-026 bin=1234 -> 1,2,3,4, overflow=0; bin=9999 -> 9,9,9,9, overflow=0; bin=10000 -> 0,0,0,0, overflow=1.
REQ-027 bin=16383 -> 6,3,8,3, overflow=1; following bin=7 -> 0,0,0,7, overflow=0.
REQ-028 Start with bin=4321, change bin to 1111 on next cycle, pulse start during op -> result 4,3,2,1, one done_tick only.
REQ-029 Start bin=5678, assert reset on 5th op cycle -> no done_tick, outputs 0, ready=1 next cycle; new start bin=42 -> 0,0,4,2.
REQ-030 start held high, bin=1..20 incrementing per accept -> every result correct, done_tick period BIN_W+2 cycles; exhaustive 0..16383 compare vs reference model.
